// File: rtl/frame_op_scheduler.sv
// Frame operation scheduler: buffers host commands in a FIFO and sequences the pixel engine per frame.
// Optional LAST_CMD_REPEAT_EN relaunches the last command when the FIFO is empty (free-running video).
module frame_op_scheduler #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_value,
    output logic        eng_start,
    output logic [2:0]  eng_op,
    output logic [7:0]  eng_value,
    input  logic        eng_hsync,
    input  logic        eng_done,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_count,
    output logic        err_timeout,
    input  logic        err_clr
);
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int PW     = $clog2(PIXELS + 1);
    localparam int SW     = $clog2(TIMEOUT + 1);
    localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP} state_t;

    state_t        state_q;
    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] pix_q, pix_d;
    logic          ovf_q, ovf_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [GW-1:0] gap_q;
    logic [15:0]   frame_count_q;
    logic [2:0]    eng_op_q;
    logic [7:0]    eng_value_q;
    logic          eng_start_q, busy_q, frame_done_q, err_count_q, err_timeout_q;
    logic          fifo_full, fifo_empty, push, pop, repeat_go, count_bad, timeout_hit;
    logic [10:0]   rd_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge HCLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_value};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pix_d = pix_q;
        ovf_d = ovf_q;
        if (eng_hsync) begin
            if (&pix_q) ovf_d = 1'b1;
            else        pix_d = pix_q + PW'(1);
        end
        stall_d     = eng_hsync ? '0 : stall_q + SW'(1);
        // A saturated counter is always a mismatch, even when all-ones happens to equal the frame size.
        count_bad   = ovf_d || (pix_d != PW'(PIXELS));
        timeout_hit = (stall_d == SW'(TIMEOUT));
    end

`ifdef LAST_CMD_REPEAT_EN
    logic have_frame_q;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)                                                  have_frame_q <= 1'b0;
        else if (state_q == S_RUN && (eng_done || timeout_hit))      have_frame_q <= 1'b1;
    end
    assign repeat_go = fifo_empty && have_frame_q;
`else
    assign repeat_go = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= S_IDLE;
            pix_q         <= '0;
            ovf_q         <= 1'b0;
            stall_q       <= '0;
            gap_q         <= '0;
            frame_count_q <= '0;
            eng_op_q      <= '0;
            eng_value_q   <= '0;
            eng_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_count_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            eng_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {eng_op_q, eng_value_q} <= rd_data;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end else if (repeat_go) begin
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    pix_q   <= '0;
                    ovf_q   <= 1'b0;
                    stall_q <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    pix_q   <= pix_d;
                    ovf_q   <= ovf_d;
                    stall_q <= stall_d;
                    if (eng_done || timeout_hit) begin
                        frame_done_q  <= eng_done;
                        frame_count_q <= frame_count_q + 16'd1;
                        gap_q         <= '0;
                        state_q       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Clear wins over a same-cycle set; flags never feed back into sequencing.
            if (err_clr) begin
                err_count_q   <= 1'b0;
                err_timeout_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (eng_done && count_bad)     err_count_q   <= 1'b1;
                if (!eng_done && timeout_hit)  err_timeout_q <= 1'b1;
            end
        end
    end

    assign cmd_ready   = !fifo_full;
    assign eng_start   = eng_start_q;
    assign eng_op      = eng_op_q;
    assign eng_value   = eng_value_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_frame_op_scheduler.sv
// Scoreboard bench for frame_op_scheduler with a small 4x2 frame; expected commands are queued on
// acceptance and compared at each eng_start.
module tb_frame_op_scheduler;
    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  cmd_value = '0;
    logic        eng_start, eng_hsync = 1'b0, eng_done = 1'b0;
    logic [2:0]  eng_op;
    logic [7:0]  eng_value;
    logic        busy, frame_done, err_count, err_timeout, err_clr = 1'b0;
    logic [15:0] frame_count;

    int          checks = 0;
    int          failures = 0;
    logic [10:0] sb [$];

    frame_op_scheduler #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .GAP_CYCLES(8), .TIMEOUT(64)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_value(cmd_value), .eng_start(eng_start), .eng_op(eng_op),
        .eng_value(eng_value), .eng_hsync(eng_hsync), .eng_done(eng_done), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count), .err_count(err_count),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic apply_reset();
        HRESET = 1'b1; cmd_valid = 1'b0; eng_hsync = 1'b0; eng_done = 1'b0; err_clr = 1'b0;
        sb.delete();
        step(); step();
        HRESET = 1'b0;
        step();
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] val, output bit acc);
        cmd_op = op; cmd_value = val; cmd_valid = 1'b1;
        acc = cmd_ready;
        if (acc) sb.push_back({op, val});
        step();
        cmd_valid = 1'b0;
    endtask

    // Waits for eng_start, then pops the scoreboard and compares the launched command.
    task automatic wait_start(input int budget, output int lat);
        logic [10:0] exp;
        lat = -1;
        for (int i = 0; i <= budget; i++) begin
            if (eng_start === 1'b1) begin lat = i; break; end
            step();
        end
        checks++;
        if (lat < 0) begin
            failures++; $display("FAIL start_timeout: no eng_start within %0d cycles", budget);
        end else if (sb.size() == 0) begin
            failures++; $display("FAIL start_unexpected: op=%0d value=%0d launched, none queued", eng_op, eng_value);
        end else begin
            exp = sb.pop_front();
            if ({eng_op, eng_value} !== exp) begin
                failures++;
                $display("FAIL start_cmd: got op=%0d value=%0d expected op=%0d value=%0d",
                         eng_op, eng_value, exp[10:8], exp[7:0]);
            end
        end
    endtask

    // Called at the first RUN negedge; returns at the first GAP negedge.
    task automatic run_frame(input int npix, input bit hs_on_done);
        for (int i = 0; i < (hs_on_done ? npix - 1 : npix); i++) begin
            eng_hsync = 1'b1; step();
        end
        eng_hsync = hs_on_done; eng_done = 1'b1;
        step();
        eng_hsync = 1'b0; eng_done = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; step();
        checks++;
        if ({eng_start, frame_done, busy, eng_op, eng_value, frame_count, err_count, err_timeout, cmd_ready}
            !== {3'b000, 3'd0, 8'd0, 16'd0, 2'b00, 1'b1}) begin
            failures++; $display("FAIL reset_outputs: busy=%0d ready=%0d count=%0d expected busy=0 ready=1 count=0",
                                 busy, cmd_ready, frame_count);
        end
        HRESET = 1'b0; step();
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || eng_start !== 1'b0) begin
            failures++; $display("FAIL reset_release: busy=%0d ready=%0d start=%0d expected 0/1/0", busy, cmd_ready, eng_start);
        end
    endtask

    task automatic test_single_frame();
        bit acc; int lat;
        apply_reset();
        push_cmd(3'd0, 8'd100, acc);
        wait_start(5, lat);
        checks++;
        if (lat + 1 !== 2) begin failures++; $display("FAIL start_latency: got %0d edges expected 2", lat + 1); end
        step();
        checks++;
        if (eng_start !== 1'b0) begin failures++; $display("FAIL start_pulse: eng_start=%0d expected 0", eng_start); end
        run_frame(8, 1'b1);
        checks++;
        if ({frame_done, frame_count, err_count, err_timeout} !== {1'b1, 16'd1, 2'b00}) begin
            failures++; $display("FAIL single_done: done=%0d count=%0d errc=%0d errt=%0d expected 1/1/0/0",
                                 frame_done, frame_count, err_count, err_timeout);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL done_pulse: frame_done=%0d expected 0", frame_done); end
        repeat (6) step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL gap_busy: busy=%0d expected 1 in last gap cycle", busy); end
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL gap_end: busy=%0d expected 0 after 8 gap cycles", busy); end
    endtask

    task automatic test_fifo_full();
        bit acc; int lat; int ready_early;
        apply_reset();
        push_cmd(3'd1, 8'd11, acc);
        wait_start(5, lat);
        step();
        for (int i = 0; i < 4; i++) begin
            push_cmd(3'(i + 2), 8'(20 + i), acc);
            checks++;
            if (acc !== 1'b1) begin failures++; $display("FAIL fifo_accept: entry %0d ready=0 expected 1", i); end
        end
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL fifo_full_ready: ready=%0d expected 0", cmd_ready); end
        push_cmd(3'd6, 8'd99, acc);
        checks++;
        if (acc !== 1'b0) begin failures++; $display("FAIL fifo_overflow: push accepted while full"); end
        run_frame(8, 1'b1);
        ready_early = 0;
        for (int i = 0; i < 20; i++) begin
            if (eng_start === 1'b1) break;
            if (cmd_ready !== 1'b0) ready_early++;
            step();
        end
        checks++;
        if (ready_early !== 0) begin failures++; $display("FAIL ready_before_pop: %0d cycles ready=1 expected 0", ready_early); end
        wait_start(0, lat);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_pop: ready=%0d expected 1", cmd_ready); end
        push_cmd(3'd6, 8'd99, acc);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL fifo_refill: push rejected after pop"); end
        run_frame(8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_start(20, lat);
            step();
            run_frame(8, 1'b1);
        end
        checks++;
        if (frame_count !== 16'd6 || sb.size() != 0) begin
            failures++; $display("FAIL fifo_order: count=%0d pending=%0d expected 6/0", frame_count, sb.size());
        end
    endtask

    task automatic test_short_frame();
        bit acc; int lat;
        apply_reset();
        push_cmd(3'd3, 8'd200, acc);
        wait_start(5, lat);
        step();
        run_frame(7, 1'b0);
        checks++;
        if ({frame_done, err_count, err_timeout} !== 3'b110) begin
            failures++; $display("FAIL short_frame: done=%0d errc=%0d errt=%0d expected 1/1/0", frame_done, err_count, err_timeout);
        end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++;
        if (err_count !== 1'b0) begin failures++; $display("FAIL err_clr: errc=%0d expected 0", err_count); end
        push_cmd(3'd7, 8'd33, acc);
        wait_start(20, lat);
        step();
        run_frame(9, 1'b1);
        checks++;
        if ({frame_done, err_count, frame_count} !== {2'b11, 16'd2}) begin
            failures++; $display("FAIL long_frame: done=%0d errc=%0d count=%0d expected 1/1/2", frame_done, err_count, frame_count);
        end
    endtask

    task automatic test_stall();
        bit acc; int lat;
        apply_reset();
        push_cmd(3'd2, 8'd50, acc);
        wait_start(5, lat);
        step();
        repeat (63) step();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL stall_early: errt=%0d busy=%0d expected 0/1 after 63 idle cycles", err_timeout, busy);
        end
        step();
        checks++;
        if ({err_timeout, frame_done, frame_count, busy} !== {2'b10, 16'd1, 1'b1}) begin
            failures++; $display("FAIL stall_abort: errt=%0d done=%0d count=%0d busy=%0d expected 1/0/1/1",
                                 err_timeout, frame_done, frame_count, busy);
        end
        repeat (8) step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL stall_idle: busy=%0d expected 0", busy); end
    endtask

    task automatic test_done_at_timeout();
        bit acc; int lat;
        apply_reset();
        push_cmd(3'd4, 8'd9, acc);
        wait_start(5, lat);
        step();
        repeat (63) step();
        eng_done = 1'b1; step(); eng_done = 1'b0;
        checks++;
        if ({frame_done, err_timeout, err_count, frame_count} !== {3'b101, 16'd1}) begin
            failures++; $display("FAIL done_vs_timeout: done=%0d errt=%0d errc=%0d count=%0d expected 1/0/1/1",
                                 frame_done, err_timeout, err_count, frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc; int lat; int activity;
        apply_reset();
        push_cmd(3'd1, 8'd77, acc);
        wait_start(5, lat);
        step();
        push_cmd(3'd2, 8'd1, acc);
        push_cmd(3'd3, 8'd2, acc);
        HRESET = 1'b1;
        #1;
        checks++;
        if ({busy, eng_op, eng_value, eng_start, cmd_ready} !== {1'b0, 3'd0, 8'd0, 2'b01}) begin
            failures++; $display("FAIL async_reset: busy=%0d op=%0d value=%0d ready=%0d expected 0/0/0/1",
                                 busy, eng_op, eng_value, cmd_ready);
        end
        sb.delete();
        step();
        HRESET = 1'b0;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (eng_start !== 1'b0 || busy !== 1'b0) activity++;
        end
        checks++;
        if (activity !== 0) begin failures++; $display("FAIL fifo_flushed: %0d active cycles expected 0", activity); end
        push_cmd(3'd5, 8'd3, acc);
        wait_start(5, lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL post_reset_latency: got %0d expected 1", lat); end
        step();
        run_frame(8, 1'b1);
        checks++;
        if ({frame_done, frame_count, err_count, err_timeout} !== {1'b1, 16'd1, 2'b00}) begin
            failures++; $display("FAIL post_reset_frame: done=%0d count=%0d expected 1/1", frame_done, frame_count);
        end
    endtask

    task automatic test_repeat();
        bit acc; int lat;
        apply_reset();
        push_cmd(3'd4, 8'h5A, acc);
        wait_start(5, lat);
        step();
        run_frame(8, 1'b1);
        checks++;
        if (frame_count !== 16'd1) begin failures++; $display("FAIL repeat_first: count=%0d expected 1", frame_count); end
`ifdef LAST_CMD_REPEAT_EN
        for (int r = 0; r < 2; r++) begin
            sb.push_back({3'd4, 8'h5A});
            wait_start(20, lat);
            checks++;
            if (lat !== 9) begin failures++; $display("FAIL repeat_latency: got %0d expected 9", lat); end
            step();
            run_frame(8, 1'b1);
            checks++;
            if (frame_count !== 16'(r + 2)) begin
                failures++; $display("FAIL repeat_count: got %0d expected %0d", frame_count, r + 2);
            end
        end
`else
        begin
            int busy_hi = 0;
            for (int i = 0; i < 40; i++) begin
                if ((i >= 8 && busy !== 1'b0) || eng_start !== 1'b0) busy_hi++;
                step();
            end
            checks++;
            if (busy_hi !== 0) begin failures++; $display("FAIL no_repeat: %0d busy cycles after gap expected 0", busy_hi); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_short_frame();
        test_stall();
        test_done_at_timeout();
        test_reset_mid_frame();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
